// File: rtl/as2650_io_pkg.sv
// Shared definitions for the AS2650 I/O-bus UART: serial FSM state encodings
// and the bit positions of the status register.
package as2650_io_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam int ST_RXV  = 0;
  localparam int ST_TXF  = 1;
  localparam int ST_TXI  = 2;
  localparam int ST_OVR  = 3;
  localparam int ST_FERR = 4;

endpackage

// File: rtl/as2650_uart_fifo.sv
// Synchronous FIFO for the UART transmit queue. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop on empty is ignored.
module as2650_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == {(AW+1){1'b0}});
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    mem_d     = mem_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/as2650_io_uart.sv
// UART peripheral on the AS2650 non-extended I/O bus: data register (TX FIFO /
// RX holding byte), control/status register, serial TX and RX engines.
module as2650_io_uart
  import as2650_io_pkg::*;
#(
  parameter logic [15:0] CLK_DIV  = 16'd104,
  parameter int          TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       opreq,
  input  logic       m_io,
  input  logic       rw,
  input  logic       wrp,
  input  logic       d_c,
  input  logic [7:0] dat_in,
  output logic [7:0] dat_out,
  output logic       dat_oe,
  output logic       rx_ready,
  output logic       txd,
  input  logic       rxd
);

  localparam int          TX_AW   = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [15:0] DIV_M1  = CLK_DIV - 16'd1;
  localparam logic [15:0] HALF_M1 = (CLK_DIV >> 1) - 16'd1;

  logic sel_s, rd_s, rd_first_s, wr_data_s, wr_ctrl_s, pop_rx_s, tx_idle_s;
  logic sel_q;
  logic [7:0] fifo_dout_s, status_s;
  logic [TX_AW:0] fifo_count_s;
  logic fifo_full_s, fifo_empty_s, fifo_pop_s;

  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_buf_q, rx_buf_d;
  logic        txd_q, txd_d, rx_meta_q, rx_s_q, rx_prev_q;
  logic        rx_valid_q, rx_valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic        rx_deliver_s, rx_ferr_set_s;

  assign sel_s      = opreq & ~m_io;
  assign rd_s       = sel_s & ~rw;
  assign rd_first_s = rd_s & ~sel_q;
  assign wr_data_s  = sel_s & rw & d_c & wrp;
  assign wr_ctrl_s  = sel_s & rw & ~d_c & wrp;
  assign pop_rx_s   = rd_first_s & d_c;
  assign tx_idle_s  = (fifo_count_s == {(TX_AW+1){1'b0}}) & (tx_state_q == UART_IDLE);

  as2650_uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8), .AW(TX_AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data_s),
    .pop   (fifo_pop_s),
    .din   (dat_in),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Bus read mux and status assembly
  always_comb begin
    status_s          = 8'h00;
    status_s[ST_RXV]  = rx_valid_q;
    status_s[ST_TXF]  = fifo_full_s;
    status_s[ST_TXI]  = tx_idle_s;
    status_s[ST_OVR]  = ovr_q;
    status_s[ST_FERR] = ferr_q;
    if (rd_s) begin
      dat_out = d_c ? rx_buf_q : status_s;
    end else begin
      dat_out = 8'h00;
    end
  end

  assign dat_oe   = rd_s;
  assign rx_ready = rx_valid_q;
  assign txd      = txd_q;

  // Transmit FSM; STOP chains directly into START when more bytes are queued
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    fifo_pop_s = 1'b0;
    case (tx_state_q)
      UART_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          tx_sh_d    = fifo_dout_s;
          tx_cnt_d   = DIV_M1;
          tx_state_d = UART_START;
        end else begin
          tx_state_d = UART_IDLE;
        end
      end
      UART_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = DIV_M1;
          tx_bit_d   = 3'd0;
          tx_state_d = UART_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      UART_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = DIV_M1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = UART_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      UART_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            tx_sh_d    = fifo_dout_s;
            tx_cnt_d   = DIV_M1;
            tx_state_d = UART_START;
          end else begin
            tx_state_d = UART_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = UART_IDLE;
    endcase
    case (tx_state_d)
      UART_START: txd_d = 1'b0;
      UART_DATA:  txd_d = tx_sh_d[0];
      default:    txd_d = 1'b1;
    endcase
  end

  // Receive FSM; a start bit still high at mid-bit is treated as a glitch
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_sh_d       = rx_sh_q;
    rx_deliver_s  = 1'b0;
    rx_ferr_set_s = 1'b0;
    case (rx_state_q)
      UART_IDLE: begin
        if (rx_prev_q & ~rx_s_q) begin
          rx_cnt_d   = HALF_M1;
          rx_state_d = UART_START;
        end else begin
          rx_state_d = UART_IDLE;
        end
      end
      UART_START: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (rx_s_q) begin
          rx_state_d = UART_IDLE;
        end else begin
          rx_cnt_d   = DIV_M1;
          rx_bit_d   = 3'd0;
          rx_state_d = UART_DATA;
        end
      end
      UART_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
          rx_cnt_d = DIV_M1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = UART_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      UART_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_deliver_s  = 1'b1;
          rx_ferr_set_s = ~rx_s_q;
          rx_state_d    = UART_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = UART_IDLE;
    endcase
  end

  // RX holding register and flags; a same-cycle read pop frees the slot first
  always_comb begin
    rx_buf_d   = rx_buf_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = ovr_q;
    ferr_d     = ferr_q;
    if (wr_ctrl_s & dat_in[0]) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end else begin
      ovr_d  = ovr_q;
      ferr_d = ferr_q;
    end
    if (rx_deliver_s) begin
      if (rx_ferr_set_s) begin
        ferr_d = 1'b1;
      end else begin
        ferr_d = ferr_d;
      end
      if (rx_valid_q & ~pop_rx_s) begin
        ovr_d = 1'b1;
      end else begin
        rx_buf_d   = rx_sh_q;
        rx_valid_d = 1'b1;
      end
    end else if (pop_rx_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // All UART state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q      <= 1'b0;
      tx_state_q <= UART_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      txd_q      <= 1'b1;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= UART_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_buf_q   <= 8'h00;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sel_q      <= sel_s;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      rx_meta_q  <= rxd;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_buf_q   <= rx_buf_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

endmodule
